// File: rtl/pair_debouncer.sv
// Two-channel debouncer: 2-flop synchronizer, stability counter and rise pulses per channel.
// Define PAIR_DEBOUNCER_GLITCH_CNT_EN to add the saturating aborted-transition counter.
module pair_debouncer #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       a_raw,
   input  logic       b_raw,
`ifdef PAIR_DEBOUNCER_GLITCH_CNT_EN
   input  logic       glitch_clr,
   output logic [7:0] glitch_cnt,
`endif
   output logic       a_out,
   output logic       b_out,
   output logic       a_rise,
   output logic       b_rise,
   output logic       both_rise
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(STABLE_CYCLES - 1);

   logic [1:0]       raw;
   logic [1:0]       s1_q, s2_q;
   logic [1:0]       out_q, out_d;
   logic [1:0]       rise_q;
   logic             both_q;
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];

   assign raw = {b_raw, a_raw};

   // cnt==0 is the STABLE state; any nonzero count is PENDING.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = '0;
         out_d[i] = out_q[i];
         if (en && (s2_q[i] != out_q[i])) begin
            if (cnt_q[i] == LastCnt) begin
               out_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         out_q    <= '0;
         rise_q   <= '0;
         both_q   <= 1'b0;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         s1_q     <= raw;
         s2_q     <= s1_q;
         out_q    <= out_d;
         rise_q   <= out_d & ~out_q;
         both_q   <= (&out_d) & ~(&out_q);
         cnt_q[0] <= cnt_d[0];
         cnt_q[1] <= cnt_d[1];
      end
   end

   assign a_out     = out_q[0];
   assign b_out     = out_q[1];
   assign a_rise    = rise_q[0];
   assign b_rise    = rise_q[1];
   assign both_rise = both_q;

`ifdef PAIR_DEBOUNCER_GLITCH_CNT_EN
   logic [1:0] abort;
   logic [8:0] glitch_sum;
   logic [7:0] glitch_q, glitch_d;

   // A disable-induced drop back to cnt==0 is not an abort.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         abort[i] = en && (s2_q[i] == out_q[i]) && (cnt_q[i] != '0);
      end
      glitch_sum = {1'b0, glitch_q} + 9'(abort[0]) + 9'(abort[1]);
      if (glitch_clr) begin
         glitch_d = '0;
      end else if (glitch_sum > 9'd255) begin
         glitch_d = 8'hff;
      end else begin
         glitch_d = glitch_sum[7:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         glitch_q <= '0;
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_pair_debouncer.sv
// Self-checking bench for pair_debouncer: directed scenarios plus random stimulus
// compared each cycle against a run-length reference model.
module tb_pair_debouncer;

   localparam int STABLE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b1;
   logic a_raw = 1'b0;
   logic b_raw = 1'b0;
   logic a_out, b_out, a_rise, b_rise, both_rise;
`ifdef PAIR_DEBOUNCER_GLITCH_CNT_EN
   logic       glitch_clr = 1'b0;
   logic [7:0] glitch_cnt;
`endif

   int n_total = 0;
   int n_bad = 0;

   // Reference model: sync pipeline plus count of consecutive enabled mismatching samples.
   bit m_s1[2], m_s2[2], m_out[2], m_rise[2];
   bit m_both;
   int m_run[2];
   int m_glitch;

   always #5 clk = ~clk;

   pair_debouncer #(
      .STABLE_CYCLES(STABLE),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .a_raw(a_raw),
      .b_raw(b_raw),
`ifdef PAIR_DEBOUNCER_GLITCH_CNT_EN
      .glitch_clr(glitch_clr),
      .glitch_cnt(glitch_cnt),
`endif
      .a_out(a_out),
      .b_out(b_out),
      .a_rise(a_rise),
      .b_rise(b_rise),
      .both_rise(both_rise)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_out[i] = 0; m_rise[i] = 0; m_run[i] = 0;
      end
      m_both = 0;
      m_glitch = 0;
   endtask

   task automatic model_step();
      bit old[2];
      bit rawv[2];
      int aborts = 0;
      rawv[0] = a_raw;
      rawv[1] = b_raw;
      for (int i = 0; i < 2; i++) begin
         old[i] = m_out[i];
         if (!en) begin
            m_run[i] = 0;
         end else if (m_s2[i] != m_out[i]) begin
            m_run[i]++;
            if (m_run[i] == STABLE) begin
               m_out[i] = m_s2[i];
               m_run[i] = 0;
            end
         end else begin
            if (m_run[i] > 0) aborts++;
            m_run[i] = 0;
         end
         m_s2[i] = m_s1[i];
         m_s1[i] = rawv[i];
         m_rise[i] = m_out[i] & !old[i];
      end
      m_both = (m_out[0] & m_out[1]) & !(old[0] & old[1]);
`ifdef PAIR_DEBOUNCER_GLITCH_CNT_EN
      if (glitch_clr) m_glitch = 0;
      else m_glitch = (m_glitch + aborts > 255) ? 255 : m_glitch + aborts;
`endif
   endtask

   task automatic compare_all();
      check("a_out", a_out, m_out[0]);
      check("b_out", b_out, m_out[1]);
      check("a_rise", a_rise, m_rise[0]);
      check("b_rise", b_rise, m_rise[1]);
      check("both_rise", both_rise, m_both);
`ifdef PAIR_DEBOUNCER_GLITCH_CNT_EN
      check("glitch_cnt", glitch_cnt, m_glitch);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic settle(input bit a, input bit b);
      a_raw = a;
      b_raw = b;
      for (int k = 0; k < 10; k++) tick();
   endtask

   initial begin
      model_reset();
      // Reset with both inputs high: everything reads 0, then rises at edge 6.
      a_raw = 1'b1;
      b_raw = 1'b1;
      #1;
      compare_all();
      tick();
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("rst_lat_a", a_out, k >= 6);
         check("rst_lat_b", b_out, k >= 6);
         check("rst_rise_a", a_rise, k == 6);
         check("rst_both", both_rise, k == 6);
      end

      // Glitch rejection: 3-cycle pulse is rejected.
      settle(0, 0);
      a_raw = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      a_raw = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("glitch_a_out", a_out, 0);
         check("glitch_a_rise", a_rise, 0);
      end
`ifdef PAIR_DEBOUNCER_GLITCH_CNT_EN
      check("glitch_cnt_one", glitch_cnt, 1);
`endif

      // Staggered rise.
      a_raw = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (k == 10) b_raw = 1'b1;
         check("stag_a_rise", a_rise, k == 6);
         check("stag_b_rise", b_rise, k == 16);
         check("stag_both", both_rise, k == 16);
      end

      // Disable freeze mid-PENDING at cnt=2.
      settle(0, 0);
      a_raw = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("dis_hold", a_out, 0);
      end
      en = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("dis_relat", a_out, k >= 4);
      end

`ifdef PAIR_DEBOUNCER_GLITCH_CNT_EN
      // Saturation, then clear colliding with an abort.
      settle(0, 0);
      for (int n = 0; n < 260; n++) begin
         a_raw = 1'b1;
         tick();
         tick();
         a_raw = 1'b0;
         for (int k = 0; k < 4; k++) tick();
      end
      check("glitch_sat", glitch_cnt, 255);
      a_raw = 1'b1;
      tick();
      tick();
      a_raw = 1'b0;
      tick();
      tick();
      glitch_clr = 1'b1;
      tick();
      glitch_clr = 1'b0;
      check("glitch_clr_prio", glitch_cnt, 0);
`endif

      // Reset mid-transition while falling on both channels.
      settle(1, 1);
      a_raw = 1'b0;
      b_raw = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      rst = 1'b1;
      #1;
      model_reset();
      check("midrst_a", a_out, 0);
      check("midrst_b", b_out, 0);
      tick();
      a_raw = 1'b1;
      b_raw = 1'b1;
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("midrst_lat", a_out & b_out, k >= 6);
      end

      // Random stimulus against the model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 5) == 0) a_raw = ~a_raw;
         if ($urandom_range(0, 5) == 0) b_raw = ~b_raw;
         en = ($urandom_range(0, 19) != 0);
`ifdef PAIR_DEBOUNCER_GLITCH_CNT_EN
         glitch_clr = ($urandom_range(0, 49) == 0);
`endif
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            #1;
            model_reset();
            compare_all();
            tick();
            rst = 1'b0;
         end else begin
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
